// File: rtl/imem_uart_loader_if.sv
// Instruction-BRAM write port bundle.
//   i_wea   : one-cycle write strobe per word
//   i_addr  : word address (ADDR_W bits)
//   i_wdata : 32-bit word to write
// master drives the port (the loader), slave receives it (the BRAM side).
interface imem_uart_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              i_wea;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_wdata;

    modport master (output i_wea, output i_addr, output i_wdata);
    modport slave  (input  i_wea, input  i_addr, input  i_wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// UART program loader for the core's instruction BRAM.
// Receives a 16-bit big-endian word count followed by big-endian 32-bit words
// over 8N1 UART, writes them to BRAM addresses 0..count-1, and keeps the core
// in reset until the load is complete.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   rx         : UART serial input (idle high, LSB first)
//   bram       : BRAM write port (i_wea / i_addr / i_wdata)
//   core_rst_n : low while loading, high once done
//   done       : load complete, sticky until reset
//   led        : {done, ovf_err, frame_err, word_idx[4:0]}
module imem_uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx,
    imem_uart_loader_if.master         bram,
    output logic                       core_rst_n,
    output logic                       done,
    output logic [7:0]                 led
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = 17;
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_LEN_HI, LD_LEN_LO, LD_DATA, LD_DONE} ld_state_t;

    rx_state_t        rx_state;
    logic             rx_s1, rx_s2, rx_q;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             frame_err;

    ld_state_t        ld_state;
    logic [15:0]      count;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;
    logic             ovf_err;

    logic [IDX_W-1:0] idx_next_c;
    logic             last_word_c;
    logic             in_range_c;

    // UART receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_q       <= 1'b1;
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_q       <= rx_s2;
            byte_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (rx_q && !rx_s2) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt  <= '0;
                        // a start bit that is high again by mid-bit was a glitch
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign idx_next_c  = word_idx + 1'b1;
    assign last_word_c = (idx_next_c == IDX_W'(count));
    assign in_range_c  = (word_idx[IDX_W-1:ADDR_W] == '0);

    // Loader: header parse, big-endian word assembly, BRAM write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state     <= LD_LEN_HI;
            count        <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            ovf_err      <= 1'b0;
            done         <= 1'b0;
            core_rst_n   <= 1'b0;
            bram.i_wea   <= 1'b0;
            bram.i_addr  <= '0;
            bram.i_wdata <= '0;
        end else begin
            bram.i_wea <= 1'b0;
            case (ld_state)
                LD_LEN_HI: begin
                    if (byte_valid) begin
                        count[15:8] <= byte_data;
                        ld_state    <= LD_LEN_LO;
                    end
                end
                LD_LEN_LO: begin
                    if (byte_valid) begin
                        count[7:0] <= byte_data;
                        word_idx   <= '0;
                        byte_idx   <= '0;
                        if ({count[15:8], byte_data} == 16'd0) begin
                            // empty program: release the core right away
                            ld_state   <= LD_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            ld_state <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (byte_valid) begin
                        word_buf <= {word_buf[15:0], byte_data};
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            // words beyond BRAM depth are consumed but not written
                            if (in_range_c) begin
                                bram.i_wea   <= 1'b1;
                                bram.i_addr  <= word_idx[ADDR_W-1:0];
                                bram.i_wdata <= {word_buf, byte_data};
                            end else begin
                                ovf_err <= 1'b1;
                            end
                            word_idx <= idx_next_c;
                            if (last_word_c) begin
                                ld_state <= LD_DONE;
                            end
                        end
                    end
                end
                LD_DONE: begin
                    done       <= 1'b1;
                    core_rst_n <= 1'b1;
                end
                default: ld_state <= LD_LEN_HI;
            endcase
        end
    end

    assign led = {done, ovf_err, frame_err, word_idx[4:0]};

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Writer side of the core's instruction-memory port: receives a program over UART, assembles 32-bit words, and writes them into instruction BRAM at addresses 0..N-1.
- Holds the core in reset until loading completes, then releases it.
- Sits beside the core wrapper and drives the BRAM write port that the core's o_addr/odata read port shares.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- ADDR_W, 10, instruction BRAM address width (1024 words).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  UART serial input; idle high; 8N1, LSB first.
- i_wea  output  1  BRAM write enable; one-cycle pulse per word.
- i_addr  output  ADDR_W  BRAM write address.
- i_wdata  output  32  BRAM write data.
- core_rst_n  output  1  low while loading; high once done.
- done  output  1  load complete; sticky until reset.
- led  output  8  status: [7] done, [6] ovf_err, [5] frame_err, [4:0] word_idx[4:0].

Behaviour:
- Reset (async, rst_n low): i_wea=0, i_addr=0, i_wdata=0, done=0, core_rst_n=0, led=0. All counters, the FSMs, and the error flags clear. Asserting reset mid-load aborts the load; after release the block waits for a new length header.
- rx synchronizer: 2 flops, both reset to 1. All sampling uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then sample. If the sample is high (glitch), go to IDLE. If low, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample = 1: byte_valid pulses for 1 cycle with the byte.
    - Sample = 0: no byte_valid; frame_err set (sticky).
    - Either way, go to IDLE.
- Loader FSM states: LEN_HI, LEN_LO, DATA, DONE. It advances only on byte_valid.
  - LEN_HI: latch count[15:8] -> LEN_LO.
  - LEN_LO: latch count[7:0].
    - Count == 0: go to DONE.
    - Otherwise: go to DATA with word_idx=0, byte_idx=0.
  - DATA: words are big-endian; the first byte goes to bits [31:24]. On the 4th byte:
    - The next cycle, i_wea=1 for exactly 1 cycle, with i_addr = word_idx[ADDR_W-1:0] and i_wdata = the assembled word.
    - word_idx increments.
    - When word_idx reaches count, go to DONE.
  - Overflow: a word with word_idx >= 2^ADDR_W is consumed but not written (i_wea stays 0), and ovf_err is set (sticky). No address wrap.
  - DONE: done=1 and core_rst_n=1 from the cycle after entry. Further bytes are ignored; i_wea never pulses again.
- Timing:
  - Latency from the final byte's byte_valid to the i_wea pulse: 1 cycle.
  - Latency from the last write to done: 1 cycle.
  - For count=0, done rises 1 cycle after the LEN_LO byte_valid.
- i_addr and i_wdata hold their last written values between pulses.
- frame_err does not alter loader state: the bad byte is simply lost.
- byte_valid and the loader transition happen in the same cycle; no buffering beyond 1 byte is needed, because bytes arrive at least 10*CLKS_PER_BIT apart.

Test Plan (CLKS_PER_BIT=16, ADDR_W=10):
- Header 0x0002, then bytes DE AD BE EF 01 23 45 67.
  - Required: two i_wea pulses, (addr 0, 0xDEADBEEF) then (addr 1, 0x01234567).
  - Required: done=1 and core_rst_n=1 1 cycle after the second pulse.
  - Required: led = 0x82.
- Header 0x0000.
  - Required: no i_wea pulse.
  - Required: done=1 1 cycle after the second header byte.
  - Send 4 more bytes: no writes.
- Low glitch on rx of 4 cycles while idle.
  - Required: no byte_valid and no state change.
- Byte with stop bit driven 0, inside a 1-word load.
  - Required: frame_err=1 and led[5]=1.
  - Required: the byte is dropped and the word completes from the next 4 valid bytes.
- Header 0x0401 (1025 words).
  - Required: 1024 pulses at addresses 0..1023 and the 1025th word not written.
  - Required: ovf_err=1 and done=1.
- rst_n pulsed low after 2 of 4 data bytes of word 0.
  - Required: immediate clear, with done=0, core_rst_n=0, i_wea=0.
  - Required: a fresh header 0x0001 plus word 0xCAFEF00D writes addr 0 = 0xCAFEF00D.
